alu_pipeline: RTL and testbench
===============================

# alu_pipeline

Three-stage pipelined integer functional unit sitting directly downstream of the ALU reservation station. It consumes the station's one-cycle issue pulse (ROB index, full instruction, two resolved operands) and drives the station's `is_functional_unit_busy` input. Each result is held on a valid/grant port toward the common data bus (CDB) arbiter until the arbiter accepts it. It also supports a pipeline flush on misprediction.

## Interface
Parameters:
- DATA_W, 16, operand/result width
- IDX_W, 4, ROB index width
- INSTR_W, 16, instruction width; opcode is instr[INSTR_W-1 -: 4]

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- flush  in  1  sync; invalidate all in-flight entries at this edge
- in_valid  in  1  issue pulse from reservation station
- in_instr_index  in  IDX_W  ROB index of issued instruction
- in_instr_full  in  INSTR_W  full instruction word
- in_val1  in  DATA_W  operand 1
- in_val2  in  DATA_W  operand 2
- busy  out  1  to station `is_functional_unit_busy`; combinational
- out_valid  out  1  result pending toward CDB
- out_instr_index  out  IDX_W  ROB index of result
- out_result  out  DATA_W  result value
- out_illegal  out  1  opcode was illegal; result forced 0
- cdb_grant  in  1  CDB arbiter accepts current result this edge
- overflow  out  1  sticky; an issue arrived with no free slot and was dropped

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR (logical), 7 SRA, 8 SLT (signed; result 1/0), 9 MUL (low DATA_W bits). 10–15 are illegal: result 0, out_illegal=1.
- Shift amount: val2[3:0]. All arithmetic wraps modulo 2^DATA_W; no flags.
- Stages:
  - E1 latches the issue, computes non-MUL results, and computes the MUL low partial (val1*val2[7:0]).
  - E2 completes MUL: adds (val1*val2[15:8])<<8, truncated.
  - WB holds the output registers.
- Movement: each stage advances when the next stage is empty or advancing. WB retires at an edge with out_valid & cdb_grant. Bubbles collapse.
- Occupancy occ = number of valid stages (0..3).
- busy = rst | ((occ + in_valid − (out_valid & cdb_grant)) >= 3). This guarantees a slot for an issue arriving the cycle after busy is sampled low, because the station issues one cycle after sampling busy.
- Dropped issue: in_valid while E1 is occupied and not advancing drops the issue and sets overflow. overflow stays set until rst.
- flush: clears all stage valid bits and out_valid. in_valid at the same edge is dropped and does not set overflow. overflow is unaffected by flush.
- cdb_grant with out_valid=0 is ignored.
- rst is dominant over flush and in_valid.
- Reset values: all valid bits 0, out_valid 0, out_instr_index 0, out_result 0, out_illegal 0, overflow 0. busy=1 while rst is high.

## Timing
- Latency: issue accepted at edge N → E1 at N, E2 at N+1, WB at N+2. out_valid is high after edge N+2 when not stalled.
- Throughput: one instruction per cycle while cdb_grant is held high.
- WB hold: out_valid, out_instr_index, out_result and out_illegal are stable from assertion until the granting edge.
- Retire and refill: at a granting edge, WB may load the E2 entry in the same edge, so there is no bubble.
- Stall: with cdb_grant low, the pipeline fills to occ=3. busy rises no later than the cycle in which the third entry is issued.
- Mid-operation reset or flush: all outputs take their reset values at that edge, except overflow under flush. Subsequent issue resumes normally.

## Structure
- Package alu_pkg: opcode localparams (OP_ADD … OP_MUL), opcode field position, default widths.
- Sub-module mul16_split: two-stage 16x16→16 multiplier with a stage-1 partial and a stage-2 final sum. Its internal register is enabled by the E1→E2 advance.
- The rest is flat in alu_pipeline: E1 result mux, occupancy/busy logic, WB register.

## Test plan
- ADD 3+4, idx 5, issued at edge 1, cdb_grant tied 1 → out_valid after edge 3, idx 5, result 7, illegal 0.
- Back-to-back issue: MUL 0x0123*0x0100, SUB 1−2, SRA 0x8000>>4, SLT −1<5 on consecutive cycles → results 0x2300, 0xFFFF, 0xF800, 1 in order on consecutive cycles.
- Backpressure: cdb_grant=0, issue 3 ADDs on consecutive cycles → busy=1 once the third is issued. A fourth pulse the cycle after busy was sampled 0 is accepted; a pulse while full sets overflow. On grant, results drain in order.
- Illegal opcode 0xC → out_illegal=1, result 0, idx preserved.
- Flush with occ=2 and in_valid=1 at the same edge → out_valid 0 and occ 0 next cycle, no result emitted, overflow unchanged.
- Reset asserted mid-stall with out_valid=1 → all outputs 0 after that edge, busy=1 during reset; a fresh ADD after reset completes with 3-edge latency.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the pipelined integer functional unit.
//   - default widths for data, ROB index and instruction word
//   - opcode encodings (opcode lives in the top OP_W bits of the instruction)
//   - helper to extract the opcode from an instruction word
package alu_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int IDX_W_DEF   = 4;
    localparam int INSTR_W_DEF = 16;

    // Opcode occupies instr[INSTR_W-1 -: OP_W].
    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB = 4'd1;
    localparam logic [OP_W-1:0] OP_AND = 4'd2;
    localparam logic [OP_W-1:0] OP_OR  = 4'd3;
    localparam logic [OP_W-1:0] OP_XOR = 4'd4;
    localparam logic [OP_W-1:0] OP_SHL = 4'd5;
    localparam logic [OP_W-1:0] OP_SHR = 4'd6;
    localparam logic [OP_W-1:0] OP_SRA = 4'd7;
    localparam logic [OP_W-1:0] OP_SLT = 4'd8;
    localparam logic [OP_W-1:0] OP_MUL = 4'd9;

    // Shift amount is taken from the low bits of operand 2.
    localparam int SHAMT_W = 4;

    function automatic logic [OP_W-1:0] get_opcode(input logic [INSTR_W_DEF-1:0] instr);
        return instr[INSTR_W_DEF-1 -: OP_W];
    endfunction

endpackage

// File: rtl/alu_pipeline_if.sv
// alu_pipeline_if: issue, result and control signals between the reservation
// station / CDB arbiter side (master) and the functional unit (slave).
//   flush            master->slave  pipeline flush on misprediction
//   in_valid         master->slave  one-cycle issue pulse
//   in_instr_index   master->slave  ROB index of the issued instruction
//   in_instr_full    master->slave  full instruction word
//   in_val1/in_val2  master->slave  resolved operands
//   cdb_grant        master->slave  CDB arbiter accepts the pending result
//   busy             slave->master  combinational is_functional_unit_busy
//   out_valid        slave->master  result pending toward the CDB
//   out_instr_index  slave->master  ROB index of the result
//   out_result       slave->master  result value
//   out_illegal      slave->master  opcode was illegal (result forced 0)
//   overflow         slave->master  sticky: an issue was dropped
//
// Handshake: an issue is a single-cycle in_valid pulse with no ready; the
// station must honour busy, sampled one cycle earlier. A result is offered
// with out_valid and held stable until the edge where out_valid & cdb_grant,
// at which point it is consumed.
interface alu_pipeline_if
    import alu_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int IDX_W   = IDX_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
);
    logic               flush;
    logic               in_valid;
    logic [IDX_W-1:0]   in_instr_index;
    logic [INSTR_W-1:0] in_instr_full;
    logic [DATA_W-1:0]  in_val1;
    logic [DATA_W-1:0]  in_val2;
    logic               cdb_grant;
    logic               busy;
    logic               out_valid;
    logic [IDX_W-1:0]   out_instr_index;
    logic [DATA_W-1:0]  out_result;
    logic               out_illegal;
    logic               overflow;

    modport master (
        output flush, in_valid, in_instr_index, in_instr_full, in_val1, in_val2, cdb_grant,
        input  busy, out_valid, out_instr_index, out_result, out_illegal, overflow
    );

    modport slave (
        input  flush, in_valid, in_instr_index, in_instr_full, in_val1, in_val2, cdb_grant,
        output busy, out_valid, out_instr_index, out_result, out_illegal, overflow
    );
endinterface

// File: rtl/mul16_split.sv
// mul16_split: two-stage W x W -> W (low bits) multiplier.
//   clk, rst  clock and synchronous active-high reset
//   en        stage register load enable (E1 -> E2 advance)
//   a, b      operands presented by stage E1
//   product   final low-W product, valid while the E2 entry is held
// Stage 1 forms a*b[HALF-1:0]; stage 2 adds (a*b[W-1:HALF]) << HALF.
module mul16_split #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] product
);
    localparam int HALF = W / 2;

    logic [W-1:0]    partial_lo;
    logic [W-1:0]    partial_q;
    logic [W-1:0]    a_q;
    logic [HALF-1:0] b_hi_q;
    logic [W-1:0]    hi_prod;

    assign partial_lo = a * {{(W-HALF){1'b0}}, b[HALF-1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            partial_q <= '0;
            a_q       <= '0;
            b_hi_q    <= '0;
        end else if (en) begin
            partial_q <= partial_lo;
            a_q       <= a;
            b_hi_q    <= b[W-1:HALF];
        end
    end

    // Only the low HALF bits of the high product survive the shift.
    assign hi_prod = a_q * {{(W-HALF){1'b0}}, b_hi_q};
    assign product = partial_q + {hi_prod[W-HALF-1:0], {HALF{1'b0}}};

endmodule

// File: rtl/alu_pipeline.sv
// alu_pipeline: three-stage (E1, E2, WB) integer functional unit between the
// ALU reservation station and the CDB arbiter.
//   clk   clock
//   rst   synchronous active-high reset, dominant over flush and issue
//   bus   alu_pipeline_if slave port (issue in, result out, busy, overflow)
// Each stage advances when the next stage is empty or advancing, so bubbles
// collapse and a granted WB entry is refilled in the same edge.
module alu_pipeline
    import alu_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int IDX_W   = IDX_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    alu_pipeline_if.slave bus
);
    // E1 stage
    logic              e1_valid;
    logic [IDX_W-1:0]  e1_idx;
    logic [OP_W-1:0]   e1_op;
    logic [DATA_W-1:0] e1_val1;
    logic [DATA_W-1:0] e1_val2;

    // E2 stage
    logic              e2_valid;
    logic [IDX_W-1:0]  e2_idx;
    logic [DATA_W-1:0] e2_result;
    logic              e2_is_mul;
    logic              e2_illegal;

    // WB stage
    logic              wb_valid;
    logic [IDX_W-1:0]  wb_idx;
    logic [DATA_W-1:0] wb_result;
    logic              wb_illegal;

    logic              overflow_q;

    // E1 combinational results
    logic [DATA_W-1:0]  e1_result;
    logic               e1_is_mul;
    logic               e1_illegal;
    logic [SHAMT_W-1:0] shamt;
    logic [DATA_W-1:0]  mul_product;
    logic [DATA_W-1:0]  e2_final;

    // Movement
    logic       retire;
    logic       wb_free;
    logic       e2_adv;
    logic       e2_free;
    logic       e1_adv;
    logic       e1_free;
    logic       accept;
    logic       drop;
    logic [2:0] occ;
    logic [2:0] busy_sum;

    // Only the opcode field of the instruction word is decoded here.
    logic unused_instr_bits;
    assign unused_instr_bits = ^bus.in_instr_full[INSTR_W-OP_W-1:0];

    assign retire  = wb_valid & bus.cdb_grant;
    assign wb_free = ~wb_valid | bus.cdb_grant;
    assign e2_adv  = e2_valid & wb_free;
    assign e2_free = ~e2_valid | wb_free;
    assign e1_adv  = e1_valid & e2_free;
    assign e1_free = ~e1_valid | e2_free;
    // An issue coinciding with flush is discarded silently.
    assign accept  = bus.in_valid & e1_free & ~bus.flush;
    assign drop    = bus.in_valid & ~e1_free & ~bus.flush;

    assign occ      = {2'b00, e1_valid} + {2'b00, e2_valid} + {2'b00, wb_valid};
    // occ + in_valid never underflows: retire implies wb_valid, so occ >= 1.
    assign busy_sum = occ + {2'b00, bus.in_valid} - {2'b00, retire};
    assign bus.busy = rst | (busy_sum >= 3'd3);

    assign shamt = e1_val2[SHAMT_W-1:0];

    always_comb begin
        e1_result  = '0;
        e1_is_mul  = 1'b0;
        e1_illegal = 1'b0;
        case (e1_op)
            OP_ADD: e1_result = e1_val1 + e1_val2;
            OP_SUB: e1_result = e1_val1 - e1_val2;
            OP_AND: e1_result = e1_val1 & e1_val2;
            OP_OR:  e1_result = e1_val1 | e1_val2;
            OP_XOR: e1_result = e1_val1 ^ e1_val2;
            OP_SHL: e1_result = e1_val1 << shamt;
            OP_SHR: e1_result = e1_val1 >> shamt;
            OP_SRA: e1_result = $signed(e1_val1) >>> shamt;
            OP_SLT: e1_result = {{(DATA_W-1){1'b0}}, ($signed(e1_val1) < $signed(e1_val2))};
            OP_MUL: e1_is_mul = 1'b1;
            default: e1_illegal = 1'b1;
        endcase
    end

    mul16_split #(
        .W (DATA_W)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .en      (e1_adv),
        .a       (e1_val1),
        .b       (e1_val2),
        .product (mul_product)
    );

    assign e2_final = e2_is_mul ? mul_product : e2_result;

    always_ff @(posedge clk) begin
        if (rst) begin
            e1_valid   <= 1'b0;
            e1_idx     <= '0;
            e1_op      <= '0;
            e1_val1    <= '0;
            e1_val2    <= '0;
            e2_valid   <= 1'b0;
            e2_idx     <= '0;
            e2_result  <= '0;
            e2_is_mul  <= 1'b0;
            e2_illegal <= 1'b0;
            wb_valid   <= 1'b0;
            wb_idx     <= '0;
            wb_result  <= '0;
            wb_illegal <= 1'b0;
            overflow_q <= 1'b0;
        end else if (bus.flush) begin
            e1_valid   <= 1'b0;
            e2_valid   <= 1'b0;
            wb_valid   <= 1'b0;
            wb_idx     <= '0;
            wb_result  <= '0;
            wb_illegal <= 1'b0;
        end else begin
            // WB: load from E2, otherwise empty out on retire.
            if (e2_adv) begin
                wb_valid   <= 1'b1;
                wb_idx     <= e2_idx;
                wb_result  <= e2_final;
                wb_illegal <= e2_illegal;
            end else if (retire) begin
                wb_valid <= 1'b0;
            end

            // E2: load from E1, otherwise empty out when it moved to WB.
            if (e1_adv) begin
                e2_valid   <= 1'b1;
                e2_idx     <= e1_idx;
                e2_result  <= e1_result;
                e2_is_mul  <= e1_is_mul;
                e2_illegal <= e1_illegal;
            end else if (e2_adv) begin
                e2_valid <= 1'b0;
            end

            // E1: latch the issue, otherwise empty out when it moved to E2.
            if (accept) begin
                e1_valid <= 1'b1;
                e1_idx   <= bus.in_instr_index;
                e1_op    <= bus.in_instr_full[INSTR_W-1 -: OP_W];
                e1_val1  <= bus.in_val1;
                e1_val2  <= bus.in_val2;
            end else if (e1_adv) begin
                e1_valid <= 1'b0;
            end

            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign bus.out_valid       = wb_valid;
    assign bus.out_instr_index = wb_idx;
    assign bus.out_result      = wb_result;
    assign bus.out_illegal     = wb_illegal;
    assign bus.overflow        = overflow_q;

endmodule

// File: tb/tb_alu_pipeline.sv
// tb_alu_pipeline: directed-vector bench for alu_pipeline. Inputs change 1ns
// after each rising edge; a negedge monitor checks every retiring result
// against an expected queue, and the main sequence checks latency, busy,
// overflow, flush and reset behaviour directly.
module tb_alu_pipeline;
    import alu_pkg::*;

    localparam int DW = 16;
    localparam int IW = 4;
    localparam int NW = 16;

    logic clk;
    logic rst;

    alu_pipeline_if #(.DATA_W(DW), .IDX_W(IW), .INSTR_W(NW)) bus ();

    alu_pipeline #(.DATA_W(DW), .IDX_W(IW), .INSTR_W(NW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Expected retire stream: {illegal, index, result}
    logic [DW+IW:0] exp_q[$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: a result is consumed at the next posedge when out_valid &
    // cdb_grant hold at the preceding negedge (inputs are stable by then).
    always @(negedge clk) begin
        if (!rst && !bus.flush && bus.out_valid && bus.cdb_grant) begin
            if (exp_q.size() == 0) begin
                check("unexpected_retire", 32'(bus.out_instr_index), 32'hFFFF_FFFF);
            end else begin
                check("retire", 32'({bus.out_illegal, bus.out_instr_index, bus.out_result}),
                      32'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid       = 1'b0;
        bus.in_instr_index = '0;
        bus.in_instr_full  = '0;
        bus.in_val1        = '0;
        bus.in_val2        = '0;
    endtask

    // Drive one issue pulse for the coming edge; optionally record its result.
    task automatic drive_issue(input logic [3:0] op, input logic [IW-1:0] idx,
                               input logic [DW-1:0] a, input logic [DW-1:0] b,
                               input logic [DW-1:0] res, input logic push);
        logic illegal;
        bus.in_valid       = 1'b1;
        bus.in_instr_index = idx;
        bus.in_instr_full  = {op, 12'h000};
        bus.in_val1        = a;
        bus.in_val2        = b;
        illegal = (op > 4'd9);
        if (push) exp_q.push_back({illegal, idx, res});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.cdb_grant = 1'b0;
        idle_inputs();

        // Reset state
        tick();
        tick();
        check("rst_busy", 32'(bus.busy), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_result", 32'(bus.out_result), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        rst = 1'b0;
        #1;
        check("idle_busy", 32'(bus.busy), 32'd0);
        tick();

        // ADD 3+4 idx 5, grant tied high: visible after the third edge
        bus.cdb_grant = 1'b1;
        drive_issue(OP_ADD, 4'd5, 16'd3, 16'd4, 16'd7, 1'b1);
        tick();
        idle_inputs();
        check("add_lat_e1", 32'(bus.out_valid), 32'd0);
        tick();
        check("add_lat_e2", 32'(bus.out_valid), 32'd0);
        tick();
        check("add_valid", 32'(bus.out_valid), 32'd1);
        check("add_idx", 32'(bus.out_instr_index), 32'd5);
        check("add_result", 32'(bus.out_result), 32'd7);
        check("add_illegal", 32'(bus.out_illegal), 32'd0);
        tick();
        check("add_retired", 32'(bus.out_valid), 32'd0);

        // Back-to-back: MUL, SUB, SRA, SLT on consecutive cycles
        drive_issue(OP_MUL, 4'd1, 16'h0123, 16'h0100, 16'h2300, 1'b1); tick();
        drive_issue(OP_SUB, 4'd2, 16'd1,    16'd2,    16'hFFFF, 1'b1); tick();
        drive_issue(OP_SRA, 4'd3, 16'h8000, 16'd4,    16'hF800, 1'b1); tick();
        check("b2b_mul_res", 32'(bus.out_result), 32'h2300);
        drive_issue(OP_SLT, 4'd4, 16'hFFFF, 16'd5,    16'h0001, 1'b1); tick();
        idle_inputs();
        check("b2b_sub_res", 32'(bus.out_result), 32'hFFFF);
        tick();
        check("b2b_sra_res", 32'(bus.out_result), 32'hF800);
        tick();
        check("b2b_slt_res", 32'(bus.out_result), 32'h0001);
        check("b2b_slt_valid", 32'(bus.out_valid), 32'd1);
        tick();
        check("b2b_drained", 32'(bus.out_valid), 32'd0);

        // More operators and wrap cases, checked through the scoreboard
        drive_issue(OP_SHL, 4'd6, 16'h0001, 16'd15,   16'h8000, 1'b1); tick();
        drive_issue(OP_SHR, 4'd7, 16'h8000, 16'd4,    16'h0800, 1'b1); tick();
        drive_issue(OP_MUL, 4'd8, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b1); tick();
        drive_issue(OP_MUL, 4'd9, 16'h1234, 16'h5678, 16'h0060, 1'b1); tick();
        drive_issue(OP_SLT, 4'hA, 16'd5,    16'hFFFF, 16'h0000, 1'b1); tick();
        drive_issue(OP_XOR, 4'hB, 16'hF0F0, 16'h0FF0, 16'hFF00, 1'b1); tick();
        idle_inputs();
        repeat (4) tick();
        check("misc_drained", 32'(bus.out_valid), 32'd0);

        // Backpressure: fill to three, then free one slot
        bus.cdb_grant = 1'b0;
        drive_issue(OP_ADD, 4'd1, 16'd1, 16'd1, 16'd2, 1'b1);
        #1 check("bp_busy_1", 32'(bus.busy), 32'd0);
        tick();
        drive_issue(OP_ADD, 4'd2, 16'd2, 16'd2, 16'd4, 1'b1);
        #1 check("bp_busy_2", 32'(bus.busy), 32'd0);
        tick();
        drive_issue(OP_ADD, 4'd3, 16'd10, 16'd5, 16'd15, 1'b1);
        #1 check("bp_busy_3", 32'(bus.busy), 32'd1);
        tick();
        idle_inputs();
        #1 check("bp_busy_full", 32'(bus.busy), 32'd1);
        check("bp_valid_full", 32'(bus.out_valid), 32'd1);
        check("bp_hold_idx", 32'(bus.out_instr_index), 32'd1);
        bus.cdb_grant = 1'b1;
        #1 check("bp_busy_grant", 32'(bus.busy), 32'd0);
        tick();
        bus.cdb_grant = 1'b0;
        drive_issue(OP_ADD, 4'd4, 16'hFFFF, 16'd2, 16'd1, 1'b1);
        tick();
        check("bp_4th_no_ovf", 32'(bus.overflow), 32'd0);
        drive_issue(OP_ADD, 4'd6, 16'd9, 16'd9, 16'd18, 1'b0);
        tick();
        idle_inputs();
        check("bp_overflow", 32'(bus.overflow), 32'd1);
        check("bp_hold_res", 32'(bus.out_result), 32'd4);
        bus.cdb_grant = 1'b1;
        repeat (3) tick();
        check("bp_drained", 32'(bus.out_valid), 32'd0);

        // Illegal opcode
        drive_issue(4'hC, 4'd9, 16'h1234, 16'h5678, 16'h0000, 1'b1);
        tick();
        idle_inputs();
        tick();
        tick();
        check("ill_valid", 32'(bus.out_valid), 32'd1);
        check("ill_flag", 32'(bus.out_illegal), 32'd1);
        check("ill_result", 32'(bus.out_result), 32'd0);
        check("ill_idx", 32'(bus.out_instr_index), 32'd9);
        tick();

        // Flush with two entries in flight and a coinciding issue
        bus.cdb_grant = 1'b0;
        drive_issue(OP_ADD, 4'd2, 16'd1, 16'd1, 16'd2, 1'b0); tick();
        drive_issue(OP_ADD, 4'd3, 16'd1, 16'd2, 16'd3, 1'b0); tick();
        drive_issue(OP_ADD, 4'd4, 16'd1, 16'd3, 16'd4, 1'b0);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        idle_inputs();
        check("flush_valid", 32'(bus.out_valid), 32'd0);
        check("flush_busy", 32'(bus.busy), 32'd0);
        check("flush_ovf_kept", 32'(bus.overflow), 32'd1);
        tick();
        tick();
        check("flush_no_emit", 32'(bus.out_valid), 32'd0);

        // Three fresh issues fit only if the flush emptied every stage
        drive_issue(OP_XOR, 4'd7, 16'hF0F0, 16'h0FF0, 16'hFF00, 1'b0); tick();
        drive_issue(OP_OR,  4'd8, 16'hF000, 16'h000F, 16'hF00F, 1'b0); tick();
        drive_issue(OP_AND, 4'd9, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0); tick();
        idle_inputs();
        check("refill_valid", 32'(bus.out_valid), 32'd1);
        check("refill_idx", 32'(bus.out_instr_index), 32'd7);
        check("refill_res", 32'(bus.out_result), 32'hFF00);
        check("refill_busy", 32'(bus.busy), 32'd1);
        check("refill_no_ovf_change", 32'(bus.overflow), 32'd1);

        // Reset mid-stall
        rst = 1'b1;
        #1 check("midrst_busy", 32'(bus.busy), 32'd1);
        tick();
        check("midrst_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_idx", 32'(bus.out_instr_index), 32'd0);
        check("midrst_res", 32'(bus.out_result), 32'd0);
        check("midrst_ill", 32'(bus.out_illegal), 32'd0);
        check("midrst_ovf", 32'(bus.overflow), 32'd0);
        rst = 1'b0;
        tick();

        // Fresh ADD after reset completes with three-edge latency
        bus.cdb_grant = 1'b1;
        drive_issue(OP_ADD, 4'd3, 16'd100, 16'd23, 16'd123, 1'b1);
        tick();
        idle_inputs();
        tick();
        check("post_rst_e2", 32'(bus.out_valid), 32'd0);
        tick();
        check("post_rst_valid", 32'(bus.out_valid), 32'd1);
        check("post_rst_res", 32'(bus.out_result), 32'd123);
        tick();
        tick();

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
